// File: rtl/ray_scheduler.sv
// ray_scheduler: raster-order primary ray dispatcher.
// Tracks in-flight rays with a tag shift register and writes results in order.
module ray_scheduler #(
    parameter int         H_RES   = 640,
    parameter int         V_RES   = 480,
    parameter int         LATENCY = 38,
    parameter logic [9:0] FOCAL   = 10'd320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [27:0] cam_pos,
    output logic [27:0] ray_init,
    output logic [30:0] ray_dir,
    output logic        ray_valid,
    input  logic [11:0] pix_color,
    input  logic        collision,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [11:0] fb_data,
    output logic [18:0] hit_count,
    output logic        busy,
    output logic        frame_done
);

    localparam int N = H_RES * V_RES;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [9:0]         x_q, x_n;
    logic [8:0]         y_q, y_n;
    logic [27:0]        init_q;
    logic [30:0]        dir_q;
    logic               valid_q;
    logic [LATENCY-1:0] tag_q;
    logic [18:0]        wr_q;
    logic               we_q;
    logic [18:0]        addr_q;
    logic [11:0]        data_q;
    logic               col_q;
    logic [18:0]        hit_q;

    logic last_ray;
    logic tag_exit;
    logic wr_done;

    assign last_ray = (x_q == 10'(H_RES - 1)) &&
                      (y_q == 9'(V_RES - 1));
    assign tag_exit = tag_q[LATENCY-1];
    assign wr_done  = (wr_q == 19'(N));

    function automatic logic [30:0] dir_of(
        input logic [9:0] x,
        input logic [8:0] y
    );
        logic [10:0] dx;
        logic [9:0]  dy;
        dx = {1'b0, x} - 11'(H_RES / 2);
        dy = 10'(V_RES / 2 - 1) - {1'b0, y};
        return {dx, dy, FOCAL};
    endfunction

    // Raster-order successor of the current pixel.
    always_comb begin
        x_n = x_q + 10'd1;
        y_n = y_q;
        if (x_q == 10'(H_RES - 1)) begin
            x_n = '0;
            y_n = y_q + 9'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state: issue all pixels, then wait for the pipeline to empty.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = ISSUE;
            ISSUE: if (last_ray) state_d = DRAIN;
            DRAIN: if (tag_q == '0 && wr_done) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ray issue, in-flight tracking and in-order framebuffer writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q     <= '0;
            y_q     <= '0;
            init_q  <= '0;
            dir_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            wr_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            col_q   <= 1'b0;
            hit_q   <= '0;
        end else begin
            tag_q <= (tag_q << 1) | LATENCY'(valid_q);
            we_q  <= tag_exit;
            if (tag_exit) begin
                data_q <= pix_color;
                col_q  <= collision;
                addr_q <= wr_q;
                wr_q   <= wr_q + 19'd1;
            end
            if (we_q && col_q) hit_q <= hit_q + 19'd1;
            unique case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        init_q  <= cam_pos;
                        x_q     <= '0;
                        y_q     <= '0;
                        dir_q   <= dir_of(10'd0, 9'd0);
                        valid_q <= 1'b1;
                        wr_q    <= '0;
                        hit_q   <= '0;
                    end
                end
                ISSUE: begin
                    if (last_ray) begin
                        valid_q <= 1'b0;
                    end else begin
                        x_q     <= x_n;
                        y_q     <= y_n;
                        dir_q   <= dir_of(x_n, y_n);
                        valid_q <= 1'b1;
                    end
                end
                default: valid_q <= 1'b0;
            endcase
        end
    end

    assign ray_init   = init_q;
    assign ray_dir    = dir_q;
    assign ray_valid  = valid_q;
    assign fb_we      = we_q;
    assign fb_addr    = addr_q;
    assign fb_data    = data_q;
    assign hit_count  = hit_q;
    assign busy       = (state_q == ISSUE) || (state_q == DRAIN);
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_ray_scheduler.sv
// tb_ray_scheduler: randomized frame tests against a pixel-level model.
// Small 4x2 frame with a 3-cycle tracer, plus wide/tall/default direction checks.
module tb_ray_scheduler;

    localparam int H = 4;
    localparam int V = 2;
    localparam int L = 3;
    localparam int N = H * V;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [27:0] cam_pos, ray_init;
    logic [30:0] ray_dir;
    logic        ray_valid, collision, fb_we, busy, frame_done;
    logic [11:0] pix_color, fb_data;
    logic [18:0] fb_addr, hit_count;

    ray_scheduler #(.H_RES(H), .V_RES(V), .LATENCY(L)) u_dut (
        .clk(clk), .rst(rst), .start(start), .cam_pos(cam_pos),
        .ray_init(ray_init), .ray_dir(ray_dir), .ray_valid(ray_valid),
        .pix_color(pix_color), .collision(collision),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .hit_count(hit_count), .busy(busy), .frame_done(frame_done)
    );

    // tracer model: 3-cycle delay, colour and collision derived from the ray
    logic [30:0] d1, d2, d3;
    logic [7:0]  mask;
    logic [3:0]  salt;
    always @(posedge clk) begin
        d1 <= ray_dir;
        d2 <= d1;
        d3 <= d2;
    end
    always_comb begin
        int xi, yi, idx;
        xi = int'($signed(d3[30:20])) + H / 2;
        yi = V / 2 - 1 - int'($signed(d3[19:10]));
        idx = yi * H + xi;
        pix_color = {d3[23:20], d3[13:10], salt};
        collision = 1'b0;
        if (idx >= 0 && idx < N) collision = mask[idx];
    end

    // auxiliary instances for direction boundary values
    logic        s_def, s_wid, s_tal;
    logic [27:0] i_def, i_wid, i_tal;
    logic [30:0] r_def, r_wid, r_tal;
    logic        v_def, v_wid, v_tal;
    logic        w_def, w_wid, w_tal;
    logic [18:0] a_def, a_wid, a_tal, h_def, h_wid, h_tal;
    logic [11:0] f_def, f_wid, f_tal;
    logic        b_def, b_wid, b_tal, n_def, n_wid, n_tal;

    ray_scheduler u_def (
        .clk(clk), .rst(rst), .start(s_def), .cam_pos(28'h0),
        .ray_init(i_def), .ray_dir(r_def), .ray_valid(v_def),
        .pix_color(12'h0), .collision(1'b0),
        .fb_we(w_def), .fb_addr(a_def), .fb_data(f_def),
        .hit_count(h_def), .busy(b_def), .frame_done(n_def)
    );
    ray_scheduler #(.H_RES(640), .V_RES(2), .LATENCY(L)) u_wid (
        .clk(clk), .rst(rst), .start(s_wid), .cam_pos(28'h0),
        .ray_init(i_wid), .ray_dir(r_wid), .ray_valid(v_wid),
        .pix_color(12'h0), .collision(1'b0),
        .fb_we(w_wid), .fb_addr(a_wid), .fb_data(f_wid),
        .hit_count(h_wid), .busy(b_wid), .frame_done(n_wid)
    );
    ray_scheduler #(.H_RES(4), .V_RES(480), .LATENCY(L)) u_tal (
        .clk(clk), .rst(rst), .start(s_tal), .cam_pos(28'h0),
        .ray_init(i_tal), .ray_dir(r_tal), .ray_valid(v_tal),
        .pix_color(12'h0), .collision(1'b0),
        .fb_we(w_tal), .fb_addr(a_tal), .fb_data(f_tal),
        .hit_count(h_tal), .busy(b_tal), .frame_done(n_tal)
    );

    // model: direction of the k-th ray of an h x v frame
    function automatic logic [30:0] exp_dir(int k, int h, int v);
        int dx, dy;
        dx = k % h - h / 2;
        dy = v / 2 - 1 - k / h;
        return {11'(dx), 10'(dy), 10'd320};
    endfunction

    // model: colour written at framebuffer address p
    function automatic logic [11:0] exp_col(int p);
        int dx, dy;
        dx = p % H - H / 2;
        dy = V / 2 - 1 - p / H;
        return {4'(dx), 4'(dy), salt};
    endfunction

    int          v_first, v_last, v_cnt, v_gap;
    int          w_first, w_last, w_cnt, w_gap;
    int          dir_bad, init_bad, busy_bad, done_cyc;
    logic [18:0] hit_c1, hit_done;
    logic [18:0] w_addr [N];
    logic [11:0] w_data [N];
    logic [27:0] b2b_cam;

    task automatic capture_frame(input logic [27:0] cam,
                                 input int s1, input int s2,
                                 input bit hold);
        int cyc;
        v_cnt = 0; v_gap = 0; v_first = 0; v_last = 0;
        w_cnt = 0; w_gap = 0; w_first = 0; w_last = 0;
        dir_bad = 0; init_bad = 0; busy_bad = 0; done_cyc = 0;
        @(negedge clk);
        cam_pos = cam;
        start = 1'b1;
        @(negedge clk);
        start = hold;
        cam_pos = ~cam;
        cyc = 1;
        while (cyc < 200 && done_cyc == 0) begin
            if (cyc == 1) hit_c1 = hit_count;
            if (ray_valid) begin
                if (v_cnt == 0) v_first = cyc;
                else if (cyc != v_last + 1) v_gap++;
                v_last = cyc;
                if (ray_init !== cam) init_bad++;
                if (ray_dir !== exp_dir(v_cnt, H, V)) dir_bad++;
                v_cnt++;
            end
            if (fb_we) begin
                if (w_cnt == 0) w_first = cyc;
                else if (cyc != w_last + 1) w_gap++;
                w_last = cyc;
                if (w_cnt < N) begin
                    w_addr[w_cnt] = fb_addr;
                    w_data[w_cnt] = fb_data;
                end
                w_cnt++;
            end
            if (frame_done) begin
                done_cyc = cyc;
                hit_done = hit_count;
                if (busy) busy_bad++;
            end else if (busy !== 1'b1) begin
                busy_bad++;
            end
            start = hold || cyc == s1 || cyc == s2;
            if (cyc == s1 || cyc == s2) cam_pos = 28'($urandom);
            if (frame_done && hold) cam_pos = b2b_cam;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        total++;
        if ({ray_valid, fb_we, busy, frame_done} !== 4'b0) begin
            $display("FAIL reset_flags got=%b want=0000",
                     {ray_valid, fb_we, busy, frame_done});
            bad++;
        end
        total++;
        if ({ray_init, ray_dir} !== 59'h0) begin
            $display("FAIL reset_ray got=%h/%h want=0", ray_init, ray_dir);
            bad++;
        end
        total++;
        if ({fb_addr, fb_data, hit_count} !== 50'h0) begin
            $display("FAIL reset_fb got=%h/%h/%h want=0",
                     fb_addr, fb_data, hit_count);
            bad++;
        end
    endtask

    task automatic test_small_frame;
        logic [27:0] cam;
        int errs;
        cam  = 28'($urandom);
        mask = 8'($urandom);
        salt = 4'($urandom);
        capture_frame(cam, 0, 0, 1'b0);
        total++;
        if (done_cyc != 13) begin
            $display("FAIL sf_done got=%0d want=13", done_cyc);
            bad++;
        end
        total++;
        if (v_first != 1 || v_cnt != N || v_gap != 0) begin
            $display("FAIL sf_valid got first=%0d cnt=%0d gap=%0d want 1/8/0",
                     v_first, v_cnt, v_gap);
            bad++;
        end
        total++;
        if (dir_bad != 0 || init_bad != 0) begin
            $display("FAIL sf_ray got dir_bad=%0d init_bad=%0d want 0/0",
                     dir_bad, init_bad);
            bad++;
        end
        total++;
        if (w_first != 5 || w_cnt != N || w_gap != 0) begin
            $display("FAIL sf_wr got first=%0d cnt=%0d gap=%0d want 5/8/0",
                     w_first, w_cnt, w_gap);
            bad++;
        end
        errs = 0;
        for (int i = 0; i < N; i++) begin
            if (w_addr[i] !== 19'(i) || w_data[i] !== exp_col(i)) begin
                $display("FAIL sf_pix%0d got=%0d:%h want=%0d:%h", i,
                         w_addr[i], w_data[i], i, exp_col(i));
                errs++;
            end
        end
        total++;
        if (errs != 0) bad++;
        total++;
        if (busy_bad != 0) begin
            $display("FAIL sf_busy got bad_cycles=%0d want 0", busy_bad);
            bad++;
        end
        total++;
        if (hit_done !== 19'($countones(mask))) begin
            $display("FAIL sf_hits got=%0d want=%0d",
                     hit_done, $countones(mask));
            bad++;
        end
        repeat (3) @(negedge clk);
        total++;
        if (ray_init !== cam || fb_we !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL sf_hold got init=%h we=%b busy=%b want %h/0/0",
                     ray_init, fb_we, busy, cam);
            bad++;
        end
    endtask

    task automatic test_collision;
        mask = 8'b1001_0010;
        salt = 4'($urandom);
        capture_frame(28'($urandom), 0, 0, 1'b0);
        total++;
        if (hit_done !== 19'd3) begin
            $display("FAIL col_hits got=%0d want=3", hit_done);
            bad++;
        end
        mask = 8'($urandom);
        capture_frame(28'($urandom), 0, 0, 1'b0);
        total++;
        if (hit_c1 !== 19'd0) begin
            $display("FAIL col_clear got=%0d want=0", hit_c1);
            bad++;
        end
        total++;
        if (hit_done !== 19'($countones(mask))) begin
            $display("FAIL col_hits2 got=%0d want=%0d",
                     hit_done, $countones(mask));
            bad++;
        end
    endtask

    task automatic test_start_ignore;
        int errs;
        mask = 8'($urandom);
        salt = 4'($urandom);
        capture_frame(28'($urandom), 3, 10, 1'b0);
        total++;
        if (done_cyc != 13 || v_cnt != N || init_bad != 0 || dir_bad != 0) begin
            $display("FAIL ign_frame got done=%0d rays=%0d ib=%0d db=%0d",
                     done_cyc, v_cnt, init_bad, dir_bad);
            bad++;
        end
        errs = (w_cnt != N || w_gap != 0) ? 1 : 0;
        for (int i = 0; i < N; i++)
            if (w_addr[i] !== 19'(i) || w_data[i] !== exp_col(i)) errs++;
        total++;
        if (errs != 0) begin
            $display("FAIL ign_writes got errors=%0d cnt=%0d want 0/8",
                     errs, w_cnt);
            bad++;
        end
        total++;
        if (hit_done !== 19'($countones(mask))) begin
            $display("FAIL ign_hits got=%0d want=%0d",
                     hit_done, $countones(mask));
            bad++;
        end
    endtask

    task automatic test_back_to_back;
        b2b_cam = 28'($urandom);
        mask = 8'($urandom);
        capture_frame(28'($urandom), 0, 0, 1'b1);
        total++;
        if (done_cyc != 13) begin
            $display("FAIL b2b_done got=%0d want=13", done_cyc);
            bad++;
        end
        total++;
        if (ray_valid !== 1'b0) begin
            $display("FAIL b2b_gap got valid=%b want 0", ray_valid);
            bad++;
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (ray_valid !== 1'b1 || ray_init !== b2b_cam ||
            ray_dir !== exp_dir(0, H, V)) begin
            $display("FAIL b2b_ray0 got v=%b init=%h dir=%h want 1/%h/%h",
                     ray_valid, ray_init, ray_dir, b2b_cam, exp_dir(0, H, V));
            bad++;
        end
        for (int i = 0; i < 30 && !frame_done; i++) @(negedge clk);
        total++;
        if (frame_done !== 1'b1) begin
            $display("FAIL b2b_frame2 got done=%b want 1", frame_done);
            bad++;
        end
    endtask

    task automatic test_reset_mid;
        int seen, spur;
        mask = 8'($urandom);
        salt = 4'($urandom);
        @(negedge clk);
        cam_pos = 28'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            if (fb_we && fb_addr == 19'd3) seen = 1;
            else @(negedge clk);
        end
        total++;
        if (seen == 0) begin
            $display("FAIL rm_wait got no write of pixel 3 want one");
            bad++;
        end
        rst = 1'b0;
        #1;
        total++;
        if ({ray_valid, fb_we, busy, frame_done, ray_init, ray_dir,
             fb_addr, fb_data, hit_count} !== 113'h0) begin
            $display("FAIL rm_clear got v=%b we=%b busy=%b hit=%0d want 0",
                     ray_valid, fb_we, busy, hit_count);
            bad++;
        end
        @(negedge clk);
        rst = 1'b1;
        spur = 0;
        repeat (20) begin
            @(negedge clk);
            if (fb_we || ray_valid || busy) spur++;
        end
        total++;
        if (spur != 0) begin
            $display("FAIL rm_quiet got active_cycles=%0d want 0", spur);
            bad++;
        end
        capture_frame(28'($urandom), 0, 0, 1'b0);
        total++;
        if (done_cyc != 13 || w_cnt != N || w_first != 5 ||
            w_addr[N-1] !== 19'(N - 1) || w_data[0] !== exp_col(0)) begin
            $display("FAIL rm_restart got done=%0d wr=%0d first=%0d",
                     done_cyc, w_cnt, w_first);
            bad++;
        end
    endtask

    task automatic test_dir_default;
        @(negedge clk);
        s_def = 1'b1;
        @(negedge clk);
        s_def = 1'b0;
        total++;
        if (v_def !== 1'b1 || r_def !== {11'h6C0, 10'd239, 10'd320}) begin
            $display("FAIL dir_ray0 got v=%b dir=%h want 1/%h", v_def,
                     r_def, {11'h6C0, 10'd239, 10'd320});
            bad++;
        end
        @(negedge clk);
        total++;
        if (r_def !== exp_dir(1, 640, 480)) begin
            $display("FAIL dir_ray1 got=%h want=%h",
                     r_def, exp_dir(1, 640, 480));
            bad++;
        end
    endtask

    task automatic test_dir_wide;
        int k, hit;
        @(negedge clk);
        s_wid = 1'b1;
        @(negedge clk);
        s_wid = 1'b0;
        k = 0;
        hit = 0;
        for (int i = 0; i < 2000 && hit == 0; i++) begin
            if (v_wid) begin
                if (k == 639) hit = 1;
                else k++;
            end
            if (hit == 0) @(negedge clk);
        end
        total++;
        if (hit == 0 || r_wid[30:20] !== 11'd319 || r_wid[19:10] !== 10'd0) begin
            $display("FAIL dir_x639 got found=%0d dx=%h dy=%h want 1/13f/0",
                     hit, r_wid[30:20], r_wid[19:10]);
            bad++;
        end
    endtask

    task automatic test_dir_tall;
        int k, hit;
        @(negedge clk);
        s_tal = 1'b1;
        @(negedge clk);
        s_tal = 1'b0;
        k = 0;
        hit = 0;
        for (int i = 0; i < 3000 && hit == 0; i++) begin
            if (v_tal) begin
                if (k == 1919) hit = 1;
                else k++;
            end
            if (hit == 0) @(negedge clk);
        end
        total++;
        if (hit == 0 || r_tal[19:10] !== 10'h310 || r_tal[30:20] !== 11'd1) begin
            $display("FAIL dir_y479 got found=%0d dx=%h dy=%h want 1/001/310",
                     hit, r_tal[30:20], r_tal[19:10]);
            bad++;
        end
        @(negedge clk);
        total++;
        if (v_tal !== 1'b0 || r_tal[19:10] !== 10'h310) begin
            $display("FAIL dir_drain got v=%b dy=%h want 0/310",
                     v_tal, r_tal[19:10]);
            bad++;
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        cam_pos = '0;
        mask = '0;
        salt = '0;
        s_def = 1'b0;
        s_wid = 1'b0;
        s_tal = 1'b0;
        b2b_cam = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_small_frame();
        test_collision();
        test_start_ignore();
        test_back_to_back();
        test_reset_mid();
        test_dir_default();
        test_dir_wide();
        test_dir_tall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
